// File: rtl/pre_if_fetch_queue.sv
// Pre-IF fetch unit: generates fetch PCs, keeps up to DEPTH instruction SRAM requests in flight,
// and hands completed {pc, inst} pairs to IF in order. Responses to redirected fetches are discarded.
module pre_if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_redirect,
  input  logic [31:0] exc_target,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        if_allow_in,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     nret_q, nret_d;
  logic [DEPTH-1:0]  stale_q, stale_d;
  logic [31:0]       pc_mem_q   [DEPTH];
  logic [31:0]       inst_mem_q [DEPTH];

  logic              redirect;
  logic [31:0]       target;
  logic              accept, resp_hit, resp_stale, store, drop_stale, pop;
  logic [PW-1:0]     resp_idx;
  logic [CW-1:0]     freed;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
    int unsigned s;
    s = 32'(p) + 32'(n);
    return PW'(s % unsigned'(DEPTH));
  endfunction

  // Returned entries always form a prefix starting at head, so the oldest pending
  // entry sits nret_q slots past head; stale entries only exist when nret_q is 0.
  always_comb begin
    redirect       = exc_redirect | br_redirect;
    target         = exc_redirect ? exc_target : br_target;
    inst_sram_req  = !rst && (count_q < CW'(DEPTH));
    inst_sram_addr = fetch_pc_q;
    accept         = inst_sram_req && inst_sram_addr_ok;
    resp_idx       = ptr_add(head_q, nret_q);
    resp_hit       = inst_sram_data_ok && (nret_q < count_q);
    resp_stale     = stale_q[resp_idx];
    store          = resp_hit && !resp_stale && !redirect;
    drop_stale     = resp_hit && resp_stale && !redirect;
    if_valid       = !rst && !redirect && (count_q != '0) && (nret_q != '0) && !stale_q[head_q];
    pop            = if_valid && if_allow_in;
    if_pc          = rst ? 32'h0 : pc_mem_q[head_q];
    if_inst        = rst ? 32'h0 : inst_mem_q[head_q];
    freed          = nret_q + CW'(resp_hit);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = accept ? ptr_add(tail_q, CW'(1)) : tail_q;
    count_d    = count_q;
    nret_d     = nret_q;
    stale_d    = stale_q;
    if (redirect) begin
      // Returned entries and the one answering right now are freed; everything left is stale.
      fetch_pc_d = target;
      head_d     = ptr_add(head_q, freed);
      count_d    = count_q - freed + CW'(accept);
      nret_d     = '0;
      stale_d    = '1;
    end else begin
      if (accept) begin
        fetch_pc_d      = fetch_pc_q + PC_STEP;
        stale_d[tail_q] = 1'b0;
      end
      if (pop || drop_stale) head_d = ptr_add(head_q, CW'(1));
      count_d = count_q + CW'(accept) - CW'(pop) - CW'(drop_stale);
      nret_d  = nret_q + CW'(store) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      nret_q     <= '0;
      stale_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      nret_q     <= nret_d;
      stale_q    <= stale_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked entirely by the control state.
  always_ff @(posedge clk) begin
    if (accept) pc_mem_q[tail_q]   <= fetch_pc_q;
    if (store)  inst_mem_q[resp_idx] <= inst_sram_rdata;
  end

endmodule

// File: tb/tb_pre_if_fetch_queue.sv
// Scoreboard bench for pre_if_fetch_queue: a bus model tracks requests, responses and redirects,
// and IF deliveries are popped from the expected queue in order.
module tb_pre_if_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_redirect = 1'b0;
  logic [31:0] exc_target = '0;
  logic        br_redirect = 1'b0;
  logic [31:0] br_target = '0;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;
  logic        if_allow_in = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  pre_if_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .PC_STEP(32'd4)) dut (
    .clk               (clk),
    .rst               (rst),
    .exc_redirect      (exc_redirect),
    .exc_target        (exc_target),
    .br_redirect       (br_redirect),
    .br_target         (br_target),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .if_allow_in       (if_allow_in),
    .if_valid          (if_valid),
    .if_pc             (if_pc),
    .if_inst           (if_inst)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic drop; } bus_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  bus_t        busq[$];
  ent_t        expq[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] m_pc;
  logic        auto_data;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] mk_inst(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_clear();
    busq.delete();
    expq.delete();
    acc_log.delete();
    pop_log.delete();
    m_pc = RESET_PC;
  endtask

  task automatic idle_inputs();
    exc_redirect = 1'b0; br_redirect = 1'b0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
    if_allow_in = 1'b1; auto_data = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock cycle: predicts this cycle's outputs, compares, then advances the model.
  task automatic step();
    bus_t r;
    ent_t e;
    int   outstanding;
    logic redir, exp_req, exp_valid, acc;
    if (auto_data) inst_sram_data_ok = (busq.size() > 0);
    inst_sram_rdata = (busq.size() > 0) ? mk_inst(busq[0].addr) : 32'hDEAD_BEEF;
    #1;
    redir       = exc_redirect | br_redirect;
    outstanding = busq.size() + expq.size();
    exp_req     = (outstanding < DEPTH);
    total++;
    if (inst_sram_req !== exp_req) begin
      bad++; $display("FAIL req: got %b want %b at %0t", inst_sram_req, exp_req, $time);
    end
    if (exp_req) begin
      total++;
      if (inst_sram_addr !== m_pc) begin
        bad++; $display("FAIL addr: got %h want %h at %0t", inst_sram_addr, m_pc, $time);
      end
    end
    exp_valid = (expq.size() > 0) && !redir;
    total++;
    if (if_valid !== exp_valid) begin
      bad++; $display("FAIL if_valid: got %b want %b at %0t", if_valid, exp_valid, $time);
    end
    if (exp_valid) begin
      total++;
      if (if_pc !== expq[0].pc || if_inst !== expq[0].inst) begin
        bad++; $display("FAIL if_data: got %h/%h want %h/%h at %0t", if_pc, if_inst, expq[0].pc, expq[0].inst, $time);
      end
      if (if_allow_in) begin
        pop_log.push_back(expq[0].pc);
        void'(expq.pop_front());
      end
    end
    if (inst_sram_data_ok && busq.size() > 0) begin
      r = busq.pop_front();
      if (!r.drop && !redir) begin
        e.pc = r.addr; e.inst = mk_inst(r.addr);
        expq.push_back(e);
      end
    end
    if (redir) begin
      expq.delete();
      foreach (busq[i]) busq[i].drop = 1'b1;
    end
    acc = exp_req && inst_sram_addr_ok;
    if (acc) begin
      r.addr = m_pc; r.drop = redir;
      busq.push_back(r);
      acc_log.push_back(m_pc);
    end
    if (redir) m_pc = exc_redirect ? exc_target : br_target;
    else if (acc) m_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_clear();
    @(posedge clk);
    #1;
    total++;
    if (inst_sram_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      bad++; $display("FAIL reset_outputs: got req=%b vld=%b pc=%h inst=%h want all 0", inst_sram_req, if_valid, if_pc, if_inst);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC) begin
      bad++; $display("FAIL reset_release: got req=%b addr=%h want 1/%h", inst_sram_req, inst_sram_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    inst_sram_addr_ok = 1'b1; auto_data = 1'b1; if_allow_in = 1'b1;
    repeat (12) step();
    total++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'h1c000000 || acc_log[1] !== 32'h1c000004 || acc_log[2] !== 32'h1c000008) begin
      bad++; $display("FAIL stream_addrs: got %0d accepts first %h want 1c000000,04,08", acc_log.size(), acc_log.size() > 0 ? acc_log[0] : 32'h0);
    end
    total++;
    if (pop_log.size() < 3 || pop_log[0] !== 32'h1c000000 || pop_log[2] !== 32'h1c000008) begin
      bad++; $display("FAIL stream_pops: got %0d pops want >=3 in order", pop_log.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_sram_addr_ok = 1'b1; auto_data = 1'b1; if_allow_in = 1'b0;
    repeat (5) step();
    total++;
    if (acc_log.size() !== 2) begin
      bad++; $display("FAIL bp_accepts: got %0d want 2", acc_log.size());
    end
    #1;
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h1c000000 || inst_sram_req !== 1'b0) begin
      bad++; $display("FAIL bp_hold: got vld=%b pc=%h req=%b want 1/1c000000/0", if_valid, if_pc, inst_sram_req);
    end
    if_allow_in = 1'b1;
    repeat (6) step();
    total++;
    if (pop_log.size() < 2 || pop_log[0] !== 32'h1c000000 || pop_log[1] !== 32'h1c000004 ||
        acc_log.size() < 3 || acc_log[2] !== 32'h1c000008) begin
      bad++; $display("FAIL bp_release: got pops=%0d accepts=%0d want ordered 000,004 then fetch 008", pop_log.size(), acc_log.size());
    end
  endtask

  task automatic test_branch();
    do_reset();
    inst_sram_addr_ok = 1'b1;
    repeat (2) step();
    br_redirect = 1'b1; br_target = 32'h1c000100;
    step();
    br_redirect = 1'b0;
    #1;
    total++;
    if (inst_sram_addr !== 32'h1c000100 || inst_sram_req !== 1'b0) begin
      bad++; $display("FAIL br_addr: got addr=%h req=%b want 1c000100/0", inst_sram_addr, inst_sram_req);
    end
    auto_data = 1'b1;
    repeat (8) step();
    total++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h1c000100) begin
      bad++; $display("FAIL br_first_pc: got %h want 1c000100", pop_log.size() > 0 ? pop_log[0] : 32'h0);
    end
  endtask

  task automatic test_priority();
    logic found;
    do_reset();
    exc_redirect = 1'b1; exc_target = 32'h1c008000;
    br_redirect = 1'b1; br_target = 32'h1c000100;
    step();
    exc_redirect = 1'b0; br_redirect = 1'b0;
    #1;
    total++;
    if (inst_sram_addr !== 32'h1c008000) begin
      bad++; $display("FAIL prio_addr: got %h want 1c008000", inst_sram_addr);
    end
    inst_sram_addr_ok = 1'b1; auto_data = 1'b1;
    repeat (8) step();
    found = 1'b0;
    foreach (acc_log[i]) if (acc_log[i] == 32'h1c000100) found = 1'b1;
    total++;
    if (found !== 1'b0 || pop_log.size() < 1 || pop_log[0] !== 32'h1c008000) begin
      bad++; $display("FAIL prio_stream: got br_fetch=%b first=%h want 0/1c008000", found, pop_log.size() > 0 ? pop_log[0] : 32'h0);
    end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    inst_sram_addr_ok = 1'b1;
    step();
    inst_sram_data_ok = 1'b1; br_redirect = 1'b1; br_target = 32'h1c000200;
    step();
    br_redirect = 1'b0; inst_sram_addr_ok = 1'b0;
    step();
    inst_sram_data_ok = 1'b0;
    #1;
    total++;
    if (if_valid !== 1'b0 || inst_sram_addr !== 32'h1c000200) begin
      bad++; $display("FAIL collide_idle: got vld=%b addr=%h want 0/1c000200", if_valid, inst_sram_addr);
    end
    inst_sram_addr_ok = 1'b1; auto_data = 1'b1;
    repeat (6) step();
    total++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h1c000200) begin
      bad++; $display("FAIL collide_first_pc: got %h want 1c000200", pop_log.size() > 0 ? pop_log[0] : 32'h0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    inst_sram_addr_ok = 1'b1;
    repeat (2) step();
    #3 rst = 1'b1;
    #1;
    total++;
    if (inst_sram_req !== 1'b0 || if_valid !== 1'b0) begin
      bad++; $display("FAIL async_rst: got req=%b vld=%b want 0/0", inst_sram_req, if_valid);
    end
    idle_inputs();
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC) begin
      bad++; $display("FAIL async_release: got req=%b addr=%h want 1/%h", inst_sram_req, inst_sram_addr, RESET_PC);
    end
    inst_sram_data_ok = 1'b1;
    step();
    inst_sram_data_ok = 1'b0;
    #1;
    total++;
    if (if_valid !== 1'b0 || inst_sram_req !== 1'b1) begin
      bad++; $display("FAIL stray_data_ok: got vld=%b req=%b want 0/1", if_valid, inst_sram_req);
    end
    inst_sram_addr_ok = 1'b1; auto_data = 1'b1;
    repeat (6) step();
    total++;
    if (pop_log.size() < 1 || pop_log[0] !== RESET_PC) begin
      bad++; $display("FAIL async_first_pc: got %h want %h", pop_log.size() > 0 ? pop_log[0] : 32'h0, RESET_PC);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    br_redirect = 1'b1; br_target = 32'hFFFF_FFFC;
    step();
    br_redirect = 1'b0;
    inst_sram_addr_ok = 1'b1; auto_data = 1'b1;
    repeat (6) step();
    total++;
    if (acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0 ||
        pop_log.size() < 2 || pop_log[1] !== 32'h0) begin
      bad++; $display("FAIL pc_wrap: got accepts=%0d pops=%0d want FFFFFFFC then 00000000", acc_log.size(), pop_log.size());
    end
  endtask

  initial begin
    auto_data = 1'b0;
    m_pc = RESET_PC;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_priority();
    test_redirect_collide();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/pre_if_fetch_queue.md
Name: pre_if_fetch_queue

Overview:
Parametrised successor of the single-entry PC register. It generates fetch addresses and issues them on the instruction SRAM req/addr_ok/data_ok bus with up to DEPTH requests in flight. It tracks outstanding PCs in an in-order queue and delivers {pc, inst} to the IF stage under a valid/allow_in handshake. Redirects (exception, branch) have a fixed priority, and all stale in-flight responses are discarded without stalling the bus.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset
DEPTH, 2, queue entries = max outstanding requests (power of 2, >=1)
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
exc_redirect  in  1  exception/ertn redirect from WB (highest priority)
exc_target  in  32  exception target
br_redirect  in  1  branch redirect from EX
br_target  in  32  branch target
inst_sram_req  out  1  fetch request
inst_sram_addr  out  32  fetch address
inst_sram_addr_ok  in  1  request accepted this cycle
inst_sram_data_ok  in  1  oldest outstanding request returns data
inst_sram_rdata  in  32  returned instruction
if_allow_in  in  1  IF stage can accept
if_valid  out  1  head entry valid for IF
if_pc  out  32  head entry PC
if_inst  out  32  head entry instruction

Behaviour:
- State:
  - fetch_pc reg.
  - Circular queue of DEPTH entries, each {pc, inst, returned, stale}.
  - head/tail pointers, count 0..DEPTH.
- Reset (async):
  - fetch_pc=RESET_PC, count=0, pointers=0, all flags cleared.
  - inst_sram_req=0, if_valid=0, if_pc=0, if_inst=0 while rst is high.
- Request side:
  - inst_sram_req = !rst && count<DEPTH.
  - inst_sram_addr = fetch_pc, combinational.
- Accept (req && addr_ok):
  - Allocate tail entry {pc=fetch_pc, returned=0, stale=0}; tail++.
  - fetch_pc += PC_STEP, mod 2^32, wrap silently.
- Response (data_ok):
  - Applies to the oldest non-returned entry (responses arrive in order).
  - Non-stale entry: store rdata, set returned.
  - Stale entry: entry freed immediately, data dropped.
  - data_ok with no pending entry is a protocol error and is ignored.
- IF side:
  - if_valid = head entry valid && returned && !stale.
  - if_pc and if_inst come from the head entry.
  - if_valid && if_allow_in pops the head (head++).
- Redirect (exc_redirect || br_redirect):
  - Target = exc_target if exc_redirect, else br_target.
  - fetch_pc <= target next cycle.
  - Every returned entry is freed.
  - Every pending entry, including one accepted this same cycle, is marked stale.
  - if_valid is forced 0 in the redirect cycle: no pop, IF sees nothing.
- Simultaneous events in one cycle:
  - accept + response + pop are all legal; count updated by the net change.
  - Redirect + data_ok: the returning data is dropped.
  - Redirect + accept: the accepted entry is stale; the next request uses the target.
- Full: count==DEPTH gives req=0. Returned-but-unconsumed entries keep req low until popped (backpressure).
- Empty: if_valid=0; req=1.
- Latency:
  - First req in the cycle after reset deasserts.
  - Redirect target appears on inst_sram_addr exactly 1 cycle after the redirect cycle.
- Reset mid-operation: all in-flight state is discarded immediately. Any data_ok arriving after reset release with count==0 is ignored.

Test Plan:
1. Reset release, addr_ok=1 every cycle, data_ok 1 cycle later, if_allow_in=1 -> addresses 1c000000, 1c000004, 1c000008…; IF gets matching pc/inst in order; count never exceeds DEPTH=2.
2. if_allow_in=0 for 5 cycles while responses return -> req drops after 2 accepts; if_valid stays 1 with pc 1c000000; after release, pops 1c000000 then 1c000004, then req resumes at 1c000008.
3. br_redirect with br_target=1c000100 while 2 requests are pending -> next addr 1c000100; both old data_ok are dropped; first if_pc delivered is 1c000100.
4. exc_redirect (1c008000) and br_redirect (1c000100) in the same cycle -> addr 1c008000; no 1c000100 fetch ever issued.
5. Redirect in the same cycle as addr_ok and data_ok -> returned data dropped; accepted entry stale; its later data_ok dropped; no spurious if_valid.
6. rst asserted asynchronously mid-cycle with 2 pending -> req and if_valid go 0 immediately; after release, addr=1c000000 and stray data_ok is ignored.
